// File: rtl/rgb_pattern_pwm.sv
// Multi-channel LED pattern generator (off / rotate / breathe / solid) driving RGBnPWM.
// Optional gamma correction of the target duty: define RGB_PATTERN_PWM_GAMMA_EN.

module rgb_pattern_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                pos_bit,
  input  logic [PWM_BITS-1:0] level,
  input  logic [PWM_BITS-1:0] pwm_ctr,
  input  logic                wrap,
  output logic                pwm
);
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_ROT = 2'd1;
  localparam logic [1:0] MODE_BRE = 2'd2;

  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0]   tgt;
  logic [PWM_BITS-1:0]   src;
  logic [PWM_BITS-1:0]   shadow;

  always_comb begin
    prod = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, duty};
    case (mode)
      MODE_OFF: tgt = '0;
      MODE_ROT: tgt = pos_bit ? '1 : '0;
      MODE_BRE: tgt = prod[2*PWM_BITS-1:PWM_BITS];
      default:  tgt = duty;
    endcase
  end

`ifdef RGB_PATTERN_PWM_GAMMA_EN
  // Squaring is registered once; the shadow still only loads at the wrap.
  logic [2*PWM_BITS-1:0] sq;
  logic [PWM_BITS-1:0]   g_q;

  always_comb sq = {{PWM_BITS{1'b0}}, tgt} * {{PWM_BITS{1'b0}}, tgt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) g_q <= '0;
    else        g_q <= sq[2*PWM_BITS-1:PWM_BITS];
  end

  assign src = g_q;
`else
  assign src = tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wrap) shadow <= src;
      pwm <= (pwm_ctr < shadow);
    end
  end
endmodule

module rgb_pattern_pwm #(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4_000_000,
  parameter int FADE_CYCLES = 15_625
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty_in,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         step_tick,
  output logic [CHANNELS-1:0]          pos
);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int FW = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_ctr;
  logic                wrap;
  logic [SW-1:0]       step_ctr;
  logic                step_last;
  logic [FW-1:0]       fade_ctr;
  logic                fade_last;
  logic                fade_tick;
  logic [PWM_BITS-1:0] level;
  logic                dir_dn;
  logic [1:0]          mode_q;
  logic                mode_chg;

  assign wrap      = (pwm_ctr == LVL_MAX);
  assign step_last = (step_ctr == STEP_LAST);
  assign fade_last = (fade_ctr == FADE_LAST);
  assign mode_chg  = (mode != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_ctr   <= '0;
      step_ctr  <= '0;
      step_tick <= 1'b0;
      pos       <= {1'b1, {(CHANNELS-1){1'b0}}};
      fade_ctr  <= '0;
      fade_tick <= 1'b0;
      mode_q    <= '0;
    end else begin
      pwm_ctr   <= pwm_ctr + 1'b1;
      step_ctr  <= step_last ? '0 : step_ctr + 1'b1;
      step_tick <= step_last;
      // pos moves on the same edge that raises step_tick
      if (step_last) pos <= {pos[0], pos[CHANNELS-1:1]};
      fade_ctr  <= fade_last ? '0 : fade_ctr + 1'b1;
      fade_tick <= fade_last;
      mode_q    <= mode;
    end
  end

  // Triangle wave; a mode change restarts it and beats a coincident fade step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= '0;
      dir_dn <= 1'b0;
    end else if (mode_chg) begin
      level  <= '0;
      dir_dn <= 1'b0;
    end else if (fade_tick) begin
      if (!dir_dn) begin
        level <= level + 1'b1;
        if (level == LVL_MAX - 1'b1) dir_dn <= 1'b1;
      end else begin
        level <= level - 1'b1;
        if (level == LVL_ONE) dir_dn <= 1'b0;
      end
    end
  end

  rgb_pattern_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane [CHANNELS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .duty    (duty_in),
    .pos_bit (pos),
    .level   (level),
    .pwm_ctr (pwm_ctr),
    .wrap    (wrap),
    .pwm     (pwm_out)
  );
endmodule

// File: tb/tb_rgb_pattern_pwm.sv
// Bench for rgb_pattern_pwm: arithmetic reference model checked every cycle plus literal pins.
module tb_rgb_pattern_pwm;
  localparam int CH = 3, PB = 4, STEP = 4, FADE = 2;
  localparam int N = 1 << PB, MAXV = N - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [CH*PB-1:0]  duty_in = '0;
  logic [CH-1:0]     pwm_out;
  logic              step_tick;
  logic [CH-1:0]     pos;

  always #5 clk = ~clk;

  rgb_pattern_pwm #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_CYCLES(STEP), .FADE_CYCLES(FADE)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .duty_in(duty_in),
    .pwm_out(pwm_out), .step_tick(step_tick), .pos(pos)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Level after f fade steps from 0 going up: triangle of period 2*MAXV.
  function automatic int tri_lvl(input int f);
    int r;
    r = f % (2 * MAXV);
    return (r <= MAXV) ? r : 2 * MAXV - r;
  endfunction

  // One-hot position after t clock edges: starts at MSB, shifts right each STEP.
  function automatic int pos_of(input int t);
    int k;
    k = (t / STEP) % CH;
    return 1 << (CH - 1 - k);
  endfunction

  function automatic int gam(input int d);
    return (d * d) >> PB;
  endfunction

  function automatic int tgt(input logic [1:0] md, input int dty, input int pbit, input int lvl);
    case (md)
      2'd0:    return 0;
      2'd1:    return pbit ? MAXV : 0;
      2'd2:    return (lvl * dty) >> PB;
      default: return dty;
    endcase
  endfunction

  // Reference model: m_t = edges since reset release, m_f = fade steps since last mode change.
  int          m_t, m_f, m_ctr, m_d, m_pv;
  int          m_sh [CH];
  int          m_gq [CH];
  logic [1:0]  m_mp;
  logic [CH-1:0] m_pwm;

  task automatic model_reset();
    m_t = 0; m_f = 0; m_mp = 2'd0; m_pwm = '0;
    for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_gq[i] = 0; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        m_ctr = m_t % N;
        m_pv  = pos_of(m_t);
        for (int i = 0; i < CH; i++) begin
          m_d = tgt(mode, int'(duty_in[i*PB +: PB]), (m_pv >> i) & 1, tri_lvl(m_f));
          m_pwm[i] = (m_ctr < m_sh[i]);
`ifdef RGB_PATTERN_PWM_GAMMA_EN
          if (m_ctr == N - 1) m_sh[i] = m_gq[i];
          m_gq[i] = gam(m_d);
`else
          if (m_ctr == N - 1) m_sh[i] = m_d;
`endif
        end
        if (mode != m_mp) m_f = 0;
        else if (m_t > 0 && m_t % FADE == 0) m_f = m_f + 1;
        m_mp = mode;
        m_t  = m_t + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("step_tick", int'(step_tick), (m_t > 0 && m_t % STEP == 0) ? 1 : 0);
      chk("pos", int'(pos), pos_of(m_t));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_duty(input int a, input int b, input int c);
    duty_in = {PB'(c), PB'(b), PB'(a)};
  endtask

  task automatic count_hi(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (N) begin
      @(negedge clk);
      c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]); c2 += int'(pwm_out[2]);
    end
  endtask

`ifdef RGB_PATTERN_PWM_GAMMA_EN
  localparam int E5 = 1, E15 = 14, E9 = 5, E8 = 4;
`else
  localparam int E5 = 5, E15 = 15, E9 = 9, E8 = 8;
`endif

  int c0, c1, c2, st, found;

  initial begin
    chk("pin_tri15", tri_lvl(15), 15);
    chk("pin_tri16", tri_lvl(16), 14);
    chk("pin_tri30", tri_lvl(30), 0);
    chk("pin_tri31", tri_lvl(31), 1);
    chk("pin_pos4", pos_of(4), 2);
    chk("pin_pos12", pos_of(12), 4);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mode = 2'(k);
      duty_in = (CH*PB)'($urandom);
      #1;
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_tick", int'(step_tick), 0);
      chk("rst_pos", int'(pos), 4);
    end

    @(negedge clk);
    mode = 2'd1;
    set_duty(0, 0, 0);
    #2 rst_n = 1'b1;

    st = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      st += int'(step_tick);
      if (c == 4)  chk("rot_pos4", int'(pos), 3'b010);
      if (c == 8)  chk("rot_pos8", int'(pos), 3'b001);
      if (c == 12) chk("rot_pos12", int'(pos), 3'b100);
    end
    chk("rot_ticks", st, 3);
    cyc(36);

    mode = 2'd3;
    set_duty(5, 0, 15);
    cyc(40);
    count_hi(c0, c1, c2);
    chk("solid_ch0", c0, E5);
    chk("solid_ch1", c1, 0);
    chk("solid_ch2", c2, E15);
    set_duty(9, 0, 15);
    cyc(40);
    count_hi(c0, c1, c2);
    chk("solid_ch0_9", c0, E9);
    set_duty(8, 0, 15);
    cyc(40);
    count_hi(c0, c1, c2);
    chk("solid_ch0_8", c0, E8);

    mode = 2'd2;
    set_duty(15, 15, 15);
    cyc(80);
    mode = 2'd3;
    cyc(6);
    mode = 2'd2;
    cyc(60);

    mode = 2'd0;
    cyc(40);
    count_hi(c0, c1, c2);
    chk("off_hi", c0 + c1 + c2, 0);

    mode = 2'd3;
    set_duty(5, 0, 15);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      if (pwm_out[2]) found = 1;
    end
    chk("wait_pwm_high", found, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", int'(pwm_out), 0);
    cyc(2);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("pos_after_rst", int'(pos), 4);
    cyc(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_pattern_pwm.md
Name: rgb_pattern_pwm

Overview:
Parametrised multi-channel LED pattern generator.
- Produces per-channel PWM waveforms for the SB_RGB_DRV PWM inputs (RGBnPWM), instantiated one level up.
- Supersedes the fixed 3-LED, on/off half-second rotator with:
  - programmable channel count;
  - PWM brightness;
  - four modes: off, rotate, breathe, solid.

Parameters:
- CHANNELS, 3, number of LED channels (>=2).
- PWM_BITS, 8, PWM resolution in bits; period = 2^PWM_BITS clk cycles.
- STEP_CYCLES, 4_000_000, clk cycles per rotate step (0.5 s at 8 MHz).
- FADE_CYCLES, 15_625, clk cycles per breathe level step.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  0=off, 1=rotate, 2=breathe, 3=solid.
- duty_in  input  CHANNELS*PWM_BITS  per-channel duty/scale; channel i at [i*PWM_BITS +: PWM_BITS].
- pwm_out  output  CHANNELS  registered PWM, bit i drives RGBiPWM.
- step_tick  output  1  one-cycle pulse on each rotate step.
- pos  output  CHANNELS  current one-hot rotate position.

Behaviour:
Reset (rst_n low, asynchronous):
- pwm_out=0, step_tick=0.
- pos = 1<<(CHANNELS-1).
- level=0, dir=up.
- All counters 0; shadow duties 0.

Timing and counters:
- Single clock domain; all state updates on posedge clk.
- pwm_ctr: PWM_BITS wide, free-running, wraps 2^PWM_BITS-1 -> 0.
- step_ctr: counts 0..STEP_CYCLES-1, then back to 0.
  - step_tick=1 for exactly the cycle after step_ctr==STEP_CYCLES-1 (registered).
  - Counts in all modes.
- fade_ctr: counts 0..FADE_CYCLES-1 identically; produces internal fade_tick.

Rotate position:
- On each step_tick event: pos <= {pos[0], pos[CHANNELS-1:1]} (rotate right).
- Advances in every mode; pos is always one-hot.

Breathe level:
- level: PWM_BITS wide, triangular.
- Each fade_tick: level steps by 1 in direction dir.
- Turn-around:
  - At 2^PWM_BITS-1, dir flips down and the next step is to max-1.
  - At 0, dir flips up.
- Each extreme is held for exactly one fade step.

Target duty d[i], selected by mode:
- off: 0.
- rotate: pos[i] ? 2^PWM_BITS-1 : 0.
- breathe: (level * duty_in[i]) >> PWM_BITS (2*PWM_BITS-bit product, upper half kept).
- solid: duty_in[i].

Shadow update:
- d is latched into shadow[i] only on the cycle pwm_ctr wraps to 0.
- Mid-period changes therefore never glitch; latency from input change to visible effect is up to one PWM period + 1 cycle.

PWM output:
- pwm_out[i] <= (pwm_ctr < shadow[i]), registered.
- Duty 0: output constantly low.
- Duty max: output high 2^PWM_BITS-1 of 2^PWM_BITS cycles.

Mode change:
- Detected against registered previous mode.
- On any change: level <= 0, dir <= up.
- pos and all counters are unaffected.
- The new duty applies at the next PWM wrap.

Simultaneous events:
- Mode change and fade_tick in the same cycle: the mode-change reset of level wins.

Reset mid-operation:
- Asynchronous clear to reset state.
- First PWM period after release starts with pwm_ctr=0.

Optional Feature:
Macro RGB_PATTERN_PWM_GAMMA_EN.
- Defined: the target duty is gamma-corrected before the shadow latch: g = (d*d) >> PWM_BITS. This gives a perceptually linear breathe.
  - Zero stays 0; max becomes 2^PWM_BITS-2 for PWM_BITS>=2.
  - One extra register stage is permitted before the shadow; shadow latching remains only at wrap.
- Undefined: linear duty, as specified above.

Test Plan:
1. Reset value: hold rst_n low, toggle mode and duty_in -> pwm_out=0, step_tick=0, pos=3'b100.
2. Rotate: CHANNELS=3, STEP_CYCLES=4, PWM_BITS=3, mode=1 -> pos 100, 010, 001, 100 every 4 cycles. pwm_out high 7 of 8 cycles only on the active channel; step_tick is one cycle wide every 4 cycles.
3. Solid: PWM_BITS=4, duty_in ch0=5, ch1=0, ch2=15 -> per 16-cycle period:
   - ch0 high 5 cycles;
   - ch1 never high;
   - ch2 high 15 cycles.
   Changing ch0 to 9 mid-period has no effect until the next pwm_ctr wrap.
4. Breathe: PWM_BITS=3, FADE_CYCLES=2, duty_in all 7 -> level sequence 0,1,...,7,6,...,0,1. Shadow duty = (level*7)>>3, i.e. 0,0,1,2,3,4,5,6 on the way up.
5. Mode change: in breathe at level 5, switch to solid then back to breathe -> level restarts at 0 going up. pos continues rotating undisturbed.
6. Async reset mid-period: assert rst_n low at pwm_ctr=3 with pwm_out high -> pwm_out goes low without waiting for a clk edge. After release, pos=100 and level=0.
7. With RGB_PATTERN_PWM_GAMMA_EN, PWM_BITS=4: solid duty 8 -> 4 high cycles per period; duty 15 -> 14 high cycles per period.
